// File: rtl/seq_chunk_adder_if.sv
// Start/busy/done operand and result bundle for seq_chunk_adder.
// Latency: none, this is wiring only.
// Backpressure: none. The master may only start an operation while busy is low.
interface seq_chunk_adder_if #(
   parameter int WIDTH = 32
) ();
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             sub;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;

   modport master (
      output start, a, b, cin, sub,
      input  busy, done, sum, cout, ovf
   );

   modport slave (
      input  start, a, b, cin, sub,
      output busy, done, sum, cout, ovf
   );
endinterface

// File: rtl/seq_chunk_adder.sv
// Multi-cycle WIDTH-bit add/subtract using one CHUNK-bit ripple slice and a registered carry.
// Latency: start accepted at edge E0, result and done pulse appear after edge E_NCH (NCH = WIDTH/CHUNK).
// Backpressure: start is ignored while busy=1. A start during the done cycle is accepted back-to-back.
// Optional macro SEQ_ADDER_SAT_EN: on signed overflow, sum saturates; cout and ovf stay raw.
module seq_chunk_adder #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 4
) (
   input  logic            clk,
   input  logic            rst,
   seq_chunk_adder_if.slave bus
);
   localparam int NCH = WIDTH / CHUNK;
   localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(NCH - 1);

   typedef enum logic {S_IDLE, S_RUN} state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;      // already inverted for subtract
   logic [WIDTH-1:0] r_acc;    // partial result, filled chunk by chunk
   logic [WIDTH-1:0] r_sum;
   logic             r_carry;
   logic [IW-1:0]    r_idx;
   logic             r_busy;
   logic             r_done;
   logic             r_cout;
   logic             r_ovf;

   int               w_base;
   logic [CHUNK-1:0] w_a_ch;
   logic [CHUNK-1:0] w_b_ch;
   logic [CHUNK:0]   w_slice;
   logic [CHUNK-1:0] w_s;
   logic             w_c_out;
   logic             w_c_msb;
   logic             w_ovf;
   logic [WIDTH-1:0] w_acc_next;
   logic [WIDTH-1:0] w_sum_final;

   // Single CHUNK-bit ripple slice working on the chunk selected by r_idx.
   always_comb begin
      w_base     = 32'(r_idx) * CHUNK;
      w_a_ch     = r_a[w_base +: CHUNK];
      w_b_ch     = r_b[w_base +: CHUNK];
      w_slice    = {1'b0, w_a_ch} + {1'b0, w_b_ch} + {{CHUNK{1'b0}}, r_carry};
      w_s        = w_slice[CHUNK-1:0];
      w_c_out    = w_slice[CHUNK];
      // Carry into the slice MSB recovered from the MSB sum bit.
      w_c_msb    = w_a_ch[CHUNK-1] ^ w_b_ch[CHUNK-1] ^ w_s[CHUNK-1];
      w_ovf      = w_c_msb ^ w_c_out;
      w_acc_next = r_acc;
      w_acc_next[w_base +: CHUNK] = w_s;
   end

`ifdef SEQ_ADDER_SAT_EN
   localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   // On overflow both addends share A's sign, so A's MSB gives the direction of the clamp.
   always_comb begin
      w_sum_final = w_acc_next;
      if (w_ovf) begin
         w_sum_final = r_a[WIDTH-1] ? SAT_NEG : SAT_POS;
      end
   end
`else
   // Wrapped result only.
   always_comb begin
      w_sum_final = w_acc_next;
   end
`endif

   // Control FSM with registered outputs: accept in IDLE, one chunk per edge in RUN.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_a     <= '0;
         r_b     <= '0;
         r_acc   <= '0;
         r_sum   <= '0;
         r_carry <= 1'b0;
         r_idx   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_cout  <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  r_a     <= bus.a;
                  r_b     <= bus.sub ? ~bus.b : bus.b;
                  r_carry <= bus.cin ^ bus.sub;
                  r_idx   <= '0;
                  r_acc   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= S_RUN;
               end
            end
            S_RUN: begin
               r_acc   <= w_acc_next;
               r_carry <= w_c_out;
               r_idx   <= r_idx + IW'(1);
               if (r_idx == LAST_IDX) begin
                  r_sum   <= w_sum_final;
                  r_cout  <= w_c_out;
                  r_ovf   <= w_ovf;
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.busy = r_busy;
   assign bus.done = r_done;
   assign bus.sum  = r_sum;
   assign bus.cout = r_cout;
   assign bus.ovf  = r_ovf;
endmodule

// File: tb/tb_seq_chunk_adder.sv
// Bench for seq_chunk_adder: three instances (CHUNK=4,1,8 at WIDTH=8) against an arithmetic reference.
// Latency: each operation is checked for NCH busy cycles and a single done cycle.
// Backpressure: checks that start is ignored while busy and accepted during done.
module tb_seq_chunk_adder;
   localparam int W = 8;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic [2:0]   t_start = '0;
   logic [W-1:0] t_a = '0;
   logic [W-1:0] t_b = '0;
   logic         t_cin = 1'b0;
   logic         t_sub = 1'b0;

   seq_chunk_adder_if #(.WIDTH(W)) if4 ();
   seq_chunk_adder_if #(.WIDTH(W)) if1 ();
   seq_chunk_adder_if #(.WIDTH(W)) if8 ();

   assign if4.start = t_start[0];
   assign if1.start = t_start[1];
   assign if8.start = t_start[2];
   assign if4.a = t_a;   assign if1.a = t_a;   assign if8.a = t_a;
   assign if4.b = t_b;   assign if1.b = t_b;   assign if8.b = t_b;
   assign if4.cin = t_cin; assign if1.cin = t_cin; assign if8.cin = t_cin;
   assign if4.sub = t_sub; assign if1.sub = t_sub; assign if8.sub = t_sub;

   seq_chunk_adder #(.WIDTH(W), .CHUNK(4)) u_c4 (.clk(clk), .rst(rst), .bus(if4.slave));
   seq_chunk_adder #(.WIDTH(W), .CHUNK(1)) u_c1 (.clk(clk), .rst(rst), .bus(if1.slave));
   seq_chunk_adder #(.WIDTH(W), .CHUNK(8)) u_c8 (.clk(clk), .rst(rst), .bus(if8.slave));

   logic [2:0]   o_busy, o_done, o_cout, o_ovf;
   logic [W-1:0] o_sum [3];
   assign o_busy = {if8.busy, if1.busy, if4.busy};
   assign o_done = {if8.done, if1.done, if4.done};
   assign o_cout = {if8.cout, if1.cout, if4.cout};
   assign o_ovf  = {if8.ovf,  if1.ovf,  if4.ovf};
   assign o_sum[0] = if4.sum;
   assign o_sum[1] = if1.sum;
   assign o_sum[2] = if8.sum;

   localparam int NCH_OF   [3] = '{2, 8, 1};
   localparam int CHUNK_OF [3] = '{4, 1, 8};

   int n_checks = 0;
   int n_errors = 0;
   logic [W-1:0] prev [3];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Reference: {ovf, cout, sum} from integer arithmetic on the true values.
   function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic cin, input logic sub);
      int ua, ub, sa, sb, ci, ut, st;
      logic [W-1:0] s;
      logic co, ov;
      ua = int'(a);
      ub = int'(b);
      sa = int'($signed(a));
      sb = int'($signed(b));
      ci = cin ? 1 : 0;
      if (!sub) begin
         ut = ua + ub + ci;
         st = sa + sb + ci;
         co = (ut > 255);
      end else begin
         ut = ua - ub - ci;
         st = sa - sb - ci;
         co = (ut >= 0);
      end
      s  = ut[W-1:0];
      ov = (st > 127) || (st < -128);
`ifdef SEQ_ADDER_SAT_EN
      if (ov) s = (st > 0) ? 8'h7F : 8'h80;
`endif
      return {ov, co, s};
   endfunction

   // Start the masked instances together, watch a fixed window, check each against the model.
   task automatic run_op(input logic [2:0] mask, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input logic sub, output logic [W+1:0] r4);
      int   bcnt [3];
      int   dcnt [3];
      logic held [3];
      logic dbusy [3];
      logic [W+1:0] res [3];
      logic [W+1:0] exp;
      exp = model(a, b, cin, sub);
      for (int k = 0; k < 3; k++) begin
         bcnt[k] = 0; dcnt[k] = 0; held[k] = 1'b1; dbusy[k] = 1'b0; res[k] = '0;
      end
      @(negedge clk);
      t_a = a; t_b = b; t_cin = cin; t_sub = sub; t_start = mask;
      for (int cyc = 0; cyc < 12; cyc++) begin
         @(negedge clk);
         for (int k = 0; k < 3; k++) begin
            if (o_busy[k]) begin
               bcnt[k]++;
               if (o_sum[k] !== prev[k]) held[k] = 1'b0;
            end
            if (o_done[k]) begin
               dcnt[k]++;
               res[k] = {o_ovf[k], o_cout[k], o_sum[k]};
               if (o_busy[k]) dbusy[k] = 1'b1;
            end
         end
         t_start = '0;
      end
      for (int k = 0; k < 3; k++) begin
         if (mask[k]) begin
            chk($sformatf("C%0d_busy_len", CHUNK_OF[k]), 32'(bcnt[k]), 32'(NCH_OF[k]));
            chk($sformatf("C%0d_done_cnt", CHUNK_OF[k]), 32'(dcnt[k]), 32'd1);
            chk($sformatf("C%0d_busy_in_done", CHUNK_OF[k]), 32'(dbusy[k]), 32'd0);
            chk($sformatf("C%0d_held_in_run", CHUNK_OF[k]), 32'(held[k]), 32'd1);
            chk($sformatf("C%0d_result", CHUNK_OF[k]), 32'(res[k]), 32'(exp));
            prev[k] = res[k][W-1:0];
         end
      end
      r4 = res[0];
   endtask

   logic [W+1:0] r;
   int dn;

   initial begin
      for (int k = 0; k < 3; k++) prev[k] = '0;
      #2 rst = 1'b1;
      #1;
      chk("rst_busy", 32'(o_busy), 32'd0);
      chk("rst_done", 32'(o_done), 32'd0);
      chk("rst_sum",  32'(o_sum[0]), 32'd0);
      chk("rst_cout", 32'(o_cout), 32'd0);
      chk("rst_ovf",  32'(o_ovf), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Directed cases with spec-given constants ({ovf,cout,sum}).
      run_op(3'b111, 8'h7F, 8'h01, 1'b0, 1'b0, r);
`ifdef SEQ_ADDER_SAT_EN
      chk("add_7f_01", 32'(r), 32'h27F);
`else
      chk("add_7f_01", 32'(r), 32'h280);
`endif
      run_op(3'b111, 8'hFF, 8'h01, 1'b0, 1'b0, r);
      chk("add_ff_01", 32'(r), 32'h100);
      run_op(3'b111, 8'h05, 8'h07, 1'b0, 1'b1, r);
      chk("sub_05_07", 32'(r), 32'h0FE);
      run_op(3'b111, 8'h80, 8'h01, 1'b0, 1'b1, r);
`ifdef SEQ_ADDER_SAT_EN
      chk("sub_80_01", 32'(r), 32'h380);
`else
      chk("sub_80_01", 32'(r), 32'h37F);
`endif

      // Start during busy is ignored; start during done is accepted (CHUNK=4 only).
      @(negedge clk);
      t_a = 8'h10; t_b = 8'h20; t_cin = 1'b0; t_sub = 1'b0; t_start = 3'b001;
      @(negedge clk);
      chk("ign_busy1", 32'(o_busy[0]), 32'd1);
      t_a = 8'hAA; t_b = 8'h55;
      @(negedge clk);
      t_start = '0;
      chk("ign_busy2", 32'(o_busy[0]), 32'd1);
      @(negedge clk);
      chk("ign_done", 32'(o_done[0]), 32'd1);
      chk("ign_sum", 32'(o_sum[0]), 32'h30);
      t_a = 8'h21; t_b = 8'h03; t_cin = 1'b1; t_start = 3'b001;
      @(negedge clk);
      t_start = '0;
      chk("b2b_done_clr", 32'(o_done[0]), 32'd0);
      chk("b2b_busy", 32'(o_busy[0]), 32'd1);
      @(negedge clk);
      chk("b2b_busy2", 32'({o_busy[0], o_done[0]}), 32'b10);
      @(negedge clk);
      chk("b2b_done", 32'({o_busy[0], o_done[0]}), 32'b01);
      chk("b2b_sum", 32'(o_sum[0]), 32'h25);
      prev[0] = o_sum[0];

      // Asynchronous reset during the first RUN cycle.
      @(negedge clk);
      t_a = 8'h12; t_b = 8'h34; t_cin = 1'b0; t_start = 3'b001;
      @(negedge clk);
      t_start = '0;
      chk("rr_busy", 32'(o_busy[0]), 32'd1);
      #1 rst = 1'b1;
      #1;
      chk("rr_busy0", 32'(o_busy[0]), 32'd0);
      chk("rr_done0", 32'(o_done[0]), 32'd0);
      chk("rr_sum0",  32'(o_sum[0]), 32'd0);
      chk("rr_cout0", 32'(o_cout[0]), 32'd0);
      chk("rr_ovf0",  32'(o_ovf[0]), 32'd0);
      #1 rst = 1'b0;
      for (int k = 0; k < 3; k++) prev[k] = '0;
      dn = 0;
      for (int cyc = 0; cyc < 6; cyc++) begin
         @(negedge clk);
         if (o_done[0] || o_busy[0]) dn++;
      end
      chk("rr_no_done", 32'(dn), 32'd0);
      run_op(3'b111, 8'h12, 8'h34, 1'b0, 1'b0, r);
      chk("rr_after", 32'(r), 32'h046);

      // Random sweep across all three chunk sizes.
      for (int i = 0; i < 30; i++) begin
         run_op(3'b111, W'($urandom_range(0, 255)), W'($urandom_range(0, 255)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), r);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
